// File: rtl/clock_set_if.sv
// Bus between the button/counter side and clock_set_ctrl.
// Carries the button pulses, the live time, and the controller outputs
// (run enable, load strobe, values to load, state and blink).
//   slave  : the controller (takes i_*, drives o_*)
//   master : the surrounding logic or a testbench (drives i_*, takes o_*)
interface clock_set_if #(
  parameter int unsigned P_SEC_BIT  = 6,
  parameter int unsigned P_MIN_BIT  = 6,
  parameter int unsigned P_HOUR_BIT = 5
);
  logic                  i_btn_mode;
  logic                  i_btn_up;
  logic                  i_btn_down;
  logic [P_SEC_BIT-1:0]  i_sec;
  logic [P_MIN_BIT-1:0]  i_min;
  logic [P_HOUR_BIT-1:0] i_hour;
  logic                  o_run_en;
  logic                  o_load;
  logic [P_SEC_BIT-1:0]  o_set_sec;
  logic [P_MIN_BIT-1:0]  o_set_min;
  logic [P_HOUR_BIT-1:0] o_set_hour;
  logic [1:0]            o_state;
  logic                  o_blink;

  modport slave (
    input  i_btn_mode, i_btn_up, i_btn_down, i_sec, i_min, i_hour,
    output o_run_en, o_load, o_set_sec, o_set_min, o_set_hour, o_state, o_blink
  );

  modport master (
    output i_btn_mode, i_btn_up, i_btn_down, i_sec, i_min, i_hour,
    input  o_run_en, o_load, o_set_sec, o_set_min, o_set_hour, o_state, o_blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the clock's counter chain.
// Owns the tick generator run enable and sequences an edit session
// (hour -> minute -> second) driven by debounced button pulses, ending in a
// one-cycle load strobe that writes the edited time into the counters.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : clock_set_if.slave
//                  i_btn_mode/up/down  one-cycle button pulses
//                  i_sec/i_min/i_hour  live time
//                  o_run_en            tick generator enable
//                  o_load, o_set_*     load strobe and values to load
//                  o_state             0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
//                  o_blink             display blink phase (0 in RUN)
module clock_set_ctrl #(
  parameter int unsigned P_SEC_BIT  = 6,
  parameter int unsigned P_MIN_BIT  = 6,
  parameter int unsigned P_HOUR_BIT = 5,
  parameter int unsigned P_TO_BIT   = 32,
  parameter int unsigned P_TIMEOUT  = 1_000_000_000,
  parameter int unsigned P_BLINK    = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  clock_set_if.slave  bus
);

  localparam int unsigned SEC_W  = P_SEC_BIT;
  localparam int unsigned MIN_W  = P_MIN_BIT;
  localparam int unsigned HOUR_W = P_HOUR_BIT;
  localparam int unsigned TO_W   = P_TO_BIT;

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_SET_HOUR = 2'd1;
  localparam logic [1:0] S_SET_MIN  = 2'd2;
  localparam logic [1:0] S_SET_SEC  = 2'd3;

  localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(59);
  localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(59);
  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(23);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(P_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   BLK_LAST = TO_W'(P_BLINK - 1);

  logic [1:0]        state_q,   state_nxt;
  logic              run_en_q,  run_en_nxt;
  logic              load_q,    load_nxt;
  logic [SEC_W-1:0]  sec_q,     sec_nxt;
  logic [MIN_W-1:0]  min_q,     min_nxt;
  logic [HOUR_W-1:0] hour_q,    hour_nxt;
  logic              blink_q,   blink_nxt;
  logic [TO_W-1:0]   to_cnt_q,  to_cnt_nxt;
  logic [TO_W-1:0]   blk_cnt_q, blk_cnt_nxt;

  // Wrapping increment/decrement; out-of-range captured values snap to 0 / max.
  logic [SEC_W-1:0]  sec_inc,  sec_dec;
  logic [MIN_W-1:0]  min_inc,  min_dec;
  logic [HOUR_W-1:0] hour_inc, hour_dec;

  assign sec_inc  = (sec_q  >= SEC_MAX)  ? '0 : sec_q  + SEC_W'(1);
  assign sec_dec  = (sec_q  == '0 || sec_q  > SEC_MAX)  ? SEC_MAX  : sec_q  - SEC_W'(1);
  assign min_inc  = (min_q  >= MIN_MAX)  ? '0 : min_q  + MIN_W'(1);
  assign min_dec  = (min_q  == '0 || min_q  > MIN_MAX)  ? MIN_MAX  : min_q  - MIN_W'(1);
  assign hour_inc = (hour_q >= HOUR_MAX) ? '0 : hour_q + HOUR_W'(1);
  assign hour_dec = (hour_q == '0 || hour_q > HOUR_MAX) ? HOUR_MAX : hour_q - HOUR_W'(1);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RUN;
      run_en_q  <= 1'b1;
      load_q    <= 1'b0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      blink_q   <= 1'b0;
      to_cnt_q  <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_nxt;
      run_en_q  <= run_en_nxt;
      load_q    <= load_nxt;
      sec_q     <= sec_nxt;
      min_q     <= min_nxt;
      hour_q    <= hour_nxt;
      blink_q   <= blink_nxt;
      to_cnt_q  <= to_cnt_nxt;
      blk_cnt_q <= blk_cnt_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state_q;
    run_en_nxt  = run_en_q;
    load_nxt    = 1'b0;
    sec_nxt     = sec_q;
    min_nxt     = min_q;
    hour_nxt    = hour_q;
    blink_nxt   = blink_q;
    to_cnt_nxt  = to_cnt_q;
    blk_cnt_nxt = blk_cnt_q;

    if (state_q == S_RUN) begin
      // run_en rises here, so after a commit it follows o_load by one cycle
      run_en_nxt  = 1'b1;
      blink_nxt   = 1'b0;
      blk_cnt_nxt = '0;
      to_cnt_nxt  = '0;
      if (bus.i_btn_mode) begin
        state_nxt  = S_SET_HOUR;
        run_en_nxt = 1'b0;
        blink_nxt  = 1'b1;
        sec_nxt    = bus.i_sec;
        min_nxt    = bus.i_min;
        hour_nxt   = bus.i_hour;
      end
    end else begin
      run_en_nxt = 1'b0;

      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_nxt = '0;
        blink_nxt   = ~blink_q;
      end else begin
        blk_cnt_nxt = blk_cnt_q + TO_W'(1);
      end

      if (bus.i_btn_mode) begin
        // mode overrides up/down; advance or commit
        to_cnt_nxt  = '0;
        blk_cnt_nxt = '0;
        if (state_q == S_SET_SEC) begin
          state_nxt = S_RUN;
          load_nxt  = 1'b1;
          blink_nxt = 1'b0;
        end else begin
          state_nxt = state_q + 2'd1;
          blink_nxt = 1'b1;
        end
      end else if (bus.i_btn_up || bus.i_btn_down) begin
        // up+down together is activity only
        to_cnt_nxt = '0;
        if (bus.i_btn_up != bus.i_btn_down) begin
          case (state_q)
            S_SET_HOUR: hour_nxt = bus.i_btn_up ? hour_inc : hour_dec;
            S_SET_MIN:  min_nxt  = bus.i_btn_up ? min_inc  : min_dec;
            default:    sec_nxt  = bus.i_btn_up ? sec_inc  : sec_dec;
          endcase
        end
      end else if (to_cnt_q == TO_LAST) begin
        // idle too long: abandon edits without loading
        state_nxt   = S_RUN;
        run_en_nxt  = 1'b1;
        blink_nxt   = 1'b0;
        blk_cnt_nxt = '0;
        to_cnt_nxt  = '0;
      end else begin
        to_cnt_nxt = to_cnt_q + TO_W'(1);
      end
    end
  end

  assign bus.o_state    = state_q;
  assign bus.o_run_en   = run_en_q;
  assign bus.o_load     = load_q;
  assign bus.o_set_sec  = sec_q;
  assign bus.o_set_min  = min_q;
  assign bus.o_set_hour = hour_q;
  assign bus.o_blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (P_TIMEOUT=8, P_BLINK=4).
module tb_clock_set_ctrl;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   load_seen;
  int   load_mark;

  clock_set_if #(.P_SEC_BIT(6), .P_MIN_BIT(6), .P_HOUR_BIT(5)) bus ();

  clock_set_ctrl #(
    .P_SEC_BIT(6), .P_MIN_BIT(6), .P_HOUR_BIT(5),
    .P_TO_BIT(32), .P_TIMEOUT(8), .P_BLINK(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_load) load_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold the buttons for one clock edge, then observe 1 time unit later.
  task automatic tick(input logic m, input logic u, input logic d);
    bus.i_btn_mode = m;
    bus.i_btn_up   = u;
    bus.i_btn_down = d;
    @(posedge clk);
    #1;
    bus.i_btn_mode = 1'b0;
    bus.i_btn_up   = 1'b0;
    bus.i_btn_down = 1'b0;
  endtask

  task automatic live(input int h, input int m, input int s);
    bus.i_hour = 5'(h);
    bus.i_min  = 6'(m);
    bus.i_sec  = 6'(s);
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hour"}, 32'(bus.o_set_hour), 32'(h));
    check({tag, ".min"},  32'(bus.o_set_min),  32'(m));
    check({tag, ".sec"},  32'(bus.o_set_sec),  32'(s));
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    load_seen = 0;
    reset = 1'b1;
    bus.i_btn_mode = 1'b0;
    bus.i_btn_up   = 1'b0;
    bus.i_btn_down = 1'b0;
    live(12, 34, 56);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset values
    check("rst.state",  32'(bus.o_state),  32'd0);
    check("rst.run_en", 32'(bus.o_run_en), 32'd1);
    check("rst.load",   32'(bus.o_load),   32'd0);
    check("rst.blink",  32'(bus.o_blink),  32'd0);
    check_time("rst", 0, 0, 0);
    tick(0, 1, 1);
    check("run.ignore_btn", 32'(bus.o_state), 32'd0);

    // main edit: 12:34:56 -> 14:33:56
    tick(1, 0, 0);
    check("main.state_h", 32'(bus.o_state),  32'd1);
    check("main.run_en0", 32'(bus.o_run_en), 32'd0);
    check_time("main.capture", 12, 34, 56);
    tick(0, 1, 0);
    check("main.hour13", 32'(bus.o_set_hour), 32'd13);
    tick(0, 1, 0);
    check("main.hour14", 32'(bus.o_set_hour), 32'd14);
    tick(1, 0, 0);
    check("main.state_m", 32'(bus.o_state), 32'd2);
    tick(0, 0, 1);
    check("main.min33", 32'(bus.o_set_min), 32'd33);
    tick(1, 0, 0);
    check("main.state_s", 32'(bus.o_state),  32'd3);
    check("main.run_en1", 32'(bus.o_run_en), 32'd0);
    tick(1, 0, 0);
    check("main.load",    32'(bus.o_load),   32'd1);
    check("main.state_r", 32'(bus.o_state),  32'd0);
    check("main.run_en2", 32'(bus.o_run_en), 32'd0);
    check_time("main.commit", 14, 33, 56);
    tick(0, 0, 0);
    check("main.load_off", 32'(bus.o_load),   32'd0);
    check("main.run_en3",  32'(bus.o_run_en), 32'd1);
    check("main.nloads",   32'(load_seen),    32'd1);

    // wrap-around at field limits
    live(23, 59, 0);
    tick(1, 0, 0);
    tick(0, 1, 0);
    check("wrap.hour_up", 32'(bus.o_set_hour), 32'd0);
    tick(0, 0, 1);
    check("wrap.hour_dn", 32'(bus.o_set_hour), 32'd23);
    tick(1, 0, 0);
    tick(0, 1, 0);
    check("wrap.min_up", 32'(bus.o_set_min), 32'd0);
    tick(1, 0, 0);
    tick(0, 0, 1);
    check("wrap.sec_dn", 32'(bus.o_set_sec), 32'd59);
    tick(1, 0, 0);
    check("wrap.load", 32'(bus.o_load), 32'd1);
    check_time("wrap.commit", 23, 0, 59);
    tick(0, 0, 0);

    // out-of-range captured hour
    live(31, 0, 0);
    tick(1, 0, 0);
    check("oor.capture", 32'(bus.o_set_hour), 32'd31);
    tick(0, 0, 1);
    check("oor.down", 32'(bus.o_set_hour), 32'd23);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 1, 0);
    check("oor.up", 32'(bus.o_set_hour), 32'd0);

    // timeout: 8 idle cycles after the up press, then RUN
    load_mark = load_seen;
    repeat (7) tick(0, 0, 0);
    check("to.still_set", 32'(bus.o_state), 32'd1);
    tick(0, 0, 0);
    check("to.state",  32'(bus.o_state),  32'd0);
    check("to.run_en", 32'(bus.o_run_en), 32'd1);
    check("to.load",   32'(bus.o_load),   32'd0);
    tick(0, 0, 0);
    check("to.noload", 32'(load_seen), 32'(load_mark));

    // simultaneous presses
    live(12, 34, 56);
    tick(1, 0, 0);
    tick(1, 1, 0);
    check("sim.mode_up_state", 32'(bus.o_state),    32'd2);
    check("sim.mode_up_hour",  32'(bus.o_set_hour), 32'd12);
    repeat (3) tick(0, 0, 0);
    tick(0, 1, 1);
    check("sim.updown_min", 32'(bus.o_set_min), 32'd34);
    repeat (7) tick(0, 0, 0);
    check("sim.to_restart", 32'(bus.o_state), 32'd2);
    tick(0, 0, 0);
    check("sim.to_fire", 32'(bus.o_state), 32'd0);
    tick(0, 0, 0);

    // reset mid-edit
    tick(1, 0, 0);
    tick(0, 1, 0);
    tick(1, 0, 0);
    tick(0, 1, 0);
    check("rst2.pending", 32'(bus.o_set_min), 32'd35);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst2.state",  32'(bus.o_state),  32'd0);
    check("rst2.run_en", 32'(bus.o_run_en), 32'd1);
    check("rst2.load",   32'(bus.o_load),   32'd0);
    check_time("rst2", 0, 0, 0);

    // blink: 1,1,1,1,0,0,0,0,1 (an up press keeps the timeout away)
    load_mark = load_seen;
    tick(1, 0, 0);
    check("blink.1", 32'(bus.o_blink), 32'd1);
    for (int i = 2; i <= 9; i++) begin
      tick(1'b0, i == 6, 1'b0);
      check($sformatf("blink.%0d", i), 32'(bus.o_blink), 32'((i <= 4) || (i == 9)));
    end
    tick(0, 0, 0);
    tick(1, 0, 0);
    check("blink.adv", 32'(bus.o_blink), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      tick(0, 0, 0);
      check($sformatf("blink.adv%0d", i), 32'(bus.o_blink), 32'(i <= 4));
    end
    tick(1, 0, 0);
    tick(1, 0, 0);
    check("blink.run",   32'(bus.o_blink), 32'd0);
    check("blink.state", 32'(bus.o_state), 32'd0);
    tick(0, 0, 0);
    check("blink.nloads", 32'(load_seen), 32'(load_mark + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
